cms_trace_controller: RTL and testbench
=======================================

# cms_trace_controller

Control-register bank and trace-window sequencer for the continuous monitoring system. It decodes host writes and reads on the 8-bit control address space, holds the trigger and monitored-range configuration, and runs the start/stop/WFI-halt state machine. It sits between the host control port and the trace datapath, and emits a one-cycle-registered, filtered instruction stream plus a free-running clock counter.

## Interface
- XLEN, 64: program counter width.
- CTRL_ADDR_WIDTH, 8: control address width.
- CTRL_DATA_WIDTH, 64: control data width.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  retired-instruction strobe.
- pc  in  XLEN  PC of the retired instruction.
- instr  in  32  encoding of the retired instruction.
- ctrl_wen  in  1  control write strobe.
- ctrl_waddr  in  CTRL_ADDR_WIDTH  write address.
- ctrl_wdata  in  CTRL_DATA_WIDTH  write data.
- ctrl_raddr  in  CTRL_ADDR_WIDTH  read address, sampled every cycle.
- ctrl_rdata  out  CTRL_DATA_WIDTH  read data, registered.
- trace_valid  out  1  filtered instruction is valid.
- trace_pc  out  XLEN  filtered PC.
- trace_instr  out  32  filtered instruction.
- tracing  out  1  high while the state is TRACING.
- wfi_stopped  out  1  high while the state is HALTED.
- clk_counter  out  64  free-running cycle counter.

## Operation
- Register map (address, access, reset value):
  - 0 start_en, RW bit0, reset 0.
  - 1 end_en, RW bit0, reset 0.
  - 2 start_addr, RW, reset 0.
  - 3 end_addr, RW, reset 0.
  - 4 lower_en, RW bit0, reset 0.
  - 5 upper_en, RW bit0, reset 0.
  - 6 lower_bound, RW, reset 0.
  - 7 upper_bound, RW, reset 0.
  - 8 wfi_stopped: reads the state. Writing 0 releases HALTED. Writing nonzero is ignored.
  - 9 clk_counter: RW, and a write loads the counter.
  - 10 last_write_timestamp: RO. Writes to this address are ignored, apart from the timestamp update below.
  - Addresses 11–255 read 0 and ignore writes.
- Every ctrl_wen updates last_write_timestamp with the clk_counter value of that cycle.
- in_range = (!lower_en || pc >= lower_bound) && (!upper_en || pc <= upper_bound). Comparisons are unsigned.
- FSM state WAIT_START (reset state):
  - start_en=0: go to TRACING on the next cycle.
  - start_en=1: an instruction with instr_valid && pc==start_addr moves to TRACING, and that instruction is itself eligible for trace.
- FSM state TRACING:
  - Each instruction with instr_valid && in_range is emitted.
  - end_en && pc==end_addr: the instruction is emitted if in range, then the FSM goes to WAIT_START.
  - instr==32'h10500073 (WFI): the instruction is emitted if in range, then the FSM goes to HALTED.
- FSM state HALTED: nothing is emitted. A write of 0 to address 8 moves to WAIT_START.
- Simultaneous events:
  - WFI and end trigger on the same instruction: HALTED wins.
  - In WAIT_START, a start match with pc==end_addr does not end the window on that same instruction.
  - A ctrl write and an instruction in the same cycle: the instruction is evaluated with the old register values.
- clk_counter increments by 1 every cycle and wraps 2^64-1 → 0. A write at address 9 sets the next value to ctrl_wdata; the increment is skipped in that cycle.

## Timing
- trace_valid, trace_pc and trace_instr are registered one cycle after the qualifying instruction. trace_valid is a single-cycle pulse per instruction.
- Back-to-back instr_valid gives back-to-back trace_valid; there is no backpressure.
- ctrl_rdata reflects ctrl_raddr with 1-cycle latency. A read in the cycle after a write returns the new value.
- tracing and wfi_stopped are registered state decodes and change in the same cycle as the state.
- Reset values: all outputs 0, all registers 0, state WAIT_START.
- Asserting rst_n low mid-window immediately drops tracing, trace_valid and wfi_stopped. No partial trace is output after reset.

## Configuration
- CMS_WFI_HALT_EN defined: WFI detection and the HALTED state are built in, as described above.
- CMS_WFI_HALT_EN undefined:
  - WFI is treated as an ordinary instruction and HALTED is unreachable.
  - wfi_stopped is tied to 0, address 8 reads 0, and writes to address 8 are ignored.

## Test plan
- Start trigger: after reset, write start_en=1, start_addr=0x1000, then retire 0x0FFC, 0x1000, 0x1004 -> trace_valid only for 0x1000 and 0x1004, each one cycle late, and tracing rises with 0x1000.
- Range filter: with lower_en=upper_en=1, bounds 0x2000–0x2FFF, retire 0x1FFC, 0x2000, 0x2FFF, 0x3000 -> only 0x2000 and 0x2FFF are emitted.
- WFI halt plus end collision (macro defined): end_addr equals the PC of a WFI -> WFI is emitted, wfi_stopped=1, and following instructions are not traced. Writing 0 to address 8 -> WAIT_START, and with start_en=0, tracing resumes the next cycle.
- Counter: write 0xFFFF_FFFF_FFFF_FFFE to address 9 -> the next two cycles read …FFFF, then 0. A subsequent write to address 3 -> address 10 reads the counter value of that write cycle.
- Reset mid-trace: pulse rst_n low while tracing -> all outputs are 0 immediately, and after release all registers read 0.
- Macro undefined: retire WFI while tracing -> no halt, wfi_stopped stays 0, and address 8 reads 0.

Source files
------------

// File: rtl/cms_trace_controller.sv
`default_nettype none
// ============================================================================
// Module   : cms_trace_controller
// Brief    : Control-register bank and start/stop/WFI-halt trace-window
//            sequencer; emits a registered, range-filtered instruction stream.
//            Optional macro CMS_WFI_HALT_EN builds in WFI detection / HALTED.
// Revision : 1.0 - initial release
// ============================================================================
module cms_trace_controller #(
  parameter int XLEN            = 64,
  parameter int CTRL_ADDR_WIDTH = 8,
  parameter int CTRL_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_valid,
  input  logic [XLEN-1:0]            pc,
  input  logic [31:0]                instr,
  input  logic                       ctrl_wen,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_waddr,
  input  logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
  input  logic [CTRL_ADDR_WIDTH-1:0] ctrl_raddr,
  output logic [CTRL_DATA_WIDTH-1:0] ctrl_rdata,
  output logic                       trace_valid,
  output logic [XLEN-1:0]            trace_pc,
  output logic [31:0]                trace_instr,
  output logic                       tracing,
  output logic                       wfi_stopped,
  output logic [63:0]                clk_counter
);

  localparam logic [1:0] c_st_wait_start = 2'd0;
  localparam logic [1:0] c_st_tracing    = 2'd1;
  localparam logic [1:0] c_st_halted     = 2'd2;

  localparam logic [CTRL_ADDR_WIDTH-1:0] c_addr_start_en    = CTRL_ADDR_WIDTH'(0);
  localparam logic [CTRL_ADDR_WIDTH-1:0] c_addr_end_en      = CTRL_ADDR_WIDTH'(1);
  localparam logic [CTRL_ADDR_WIDTH-1:0] c_addr_start_addr  = CTRL_ADDR_WIDTH'(2);
  localparam logic [CTRL_ADDR_WIDTH-1:0] c_addr_end_addr    = CTRL_ADDR_WIDTH'(3);
  localparam logic [CTRL_ADDR_WIDTH-1:0] c_addr_lower_en    = CTRL_ADDR_WIDTH'(4);
  localparam logic [CTRL_ADDR_WIDTH-1:0] c_addr_upper_en    = CTRL_ADDR_WIDTH'(5);
  localparam logic [CTRL_ADDR_WIDTH-1:0] c_addr_lower_bound = CTRL_ADDR_WIDTH'(6);
  localparam logic [CTRL_ADDR_WIDTH-1:0] c_addr_upper_bound = CTRL_ADDR_WIDTH'(7);
  localparam logic [CTRL_ADDR_WIDTH-1:0] c_addr_wfi_stopped = CTRL_ADDR_WIDTH'(8);
  localparam logic [CTRL_ADDR_WIDTH-1:0] c_addr_clk_counter = CTRL_ADDR_WIDTH'(9);
  localparam logic [CTRL_ADDR_WIDTH-1:0] c_addr_last_ts     = CTRL_ADDR_WIDTH'(10);

  logic [1:0]                 state_q, state_d;
  logic                       start_en_q, start_en_d, end_en_q, end_en_d;
  logic                       lower_en_q, lower_en_d, upper_en_q, upper_en_d;
  logic [CTRL_DATA_WIDTH-1:0] start_addr_q, start_addr_d, end_addr_q, end_addr_d;
  logic [CTRL_DATA_WIDTH-1:0] lower_bound_q, lower_bound_d, upper_bound_q, upper_bound_d;
  logic [63:0]                clk_counter_q, clk_counter_d, last_ts_q, last_ts_d;
  logic [CTRL_DATA_WIDTH-1:0] ctrl_rdata_q, ctrl_rdata_d;
  logic                       trace_valid_q, trace_valid_d;
  logic [XLEN-1:0]            trace_pc_q, trace_pc_d;
  logic [31:0]                trace_instr_q, trace_instr_d;
  logic                       tracing_q, tracing_d, wfi_stopped_q, wfi_stopped_d;

  logic [CTRL_DATA_WIDTH-1:0] w_pc;
  logic                       w_in_range, w_start_hit, w_end_hit, w_is_wfi, w_halt_release;

  assign w_pc        = CTRL_DATA_WIDTH'(pc);
  assign w_in_range  = (!lower_en_q || (w_pc >= lower_bound_q)) &&
                       (!upper_en_q || (w_pc <= upper_bound_q));
  assign w_start_hit = instr_valid && (w_pc == start_addr_q);
  assign w_end_hit   = instr_valid && end_en_q && (w_pc == end_addr_q);

`ifdef CMS_WFI_HALT_EN
  localparam logic [31:0] c_wfi = 32'h10500073;
  assign w_is_wfi       = instr_valid && (instr == c_wfi);
  assign w_halt_release = ctrl_wen && (ctrl_waddr == c_addr_wfi_stopped) && (ctrl_wdata == '0);
`else
  assign w_is_wfi       = 1'b0;
  assign w_halt_release = 1'b0;
`endif

  // Register bank; instructions in this cycle still see the old values.
  always_comb begin
    start_en_d    = start_en_q;
    end_en_d      = end_en_q;
    start_addr_d  = start_addr_q;
    end_addr_d    = end_addr_q;
    lower_en_d    = lower_en_q;
    upper_en_d    = upper_en_q;
    lower_bound_d = lower_bound_q;
    upper_bound_d = upper_bound_q;
    clk_counter_d = clk_counter_q + 64'd1;
    last_ts_d     = last_ts_q;
    if (ctrl_wen) begin
      last_ts_d = clk_counter_q;
      case (ctrl_waddr)
        c_addr_start_en:    start_en_d    = ctrl_wdata[0];
        c_addr_end_en:      end_en_d      = ctrl_wdata[0];
        c_addr_start_addr:  start_addr_d  = ctrl_wdata;
        c_addr_end_addr:    end_addr_d    = ctrl_wdata;
        c_addr_lower_en:    lower_en_d    = ctrl_wdata[0];
        c_addr_upper_en:    upper_en_d    = ctrl_wdata[0];
        c_addr_lower_bound: lower_bound_d = ctrl_wdata;
        c_addr_upper_bound: upper_bound_d = ctrl_wdata;
        c_addr_clk_counter: clk_counter_d = 64'(ctrl_wdata);
        default: ;
      endcase
    end
  end

  always_comb begin
    ctrl_rdata_d = '0;
    case (ctrl_raddr)
      c_addr_start_en:    ctrl_rdata_d = CTRL_DATA_WIDTH'(start_en_q);
      c_addr_end_en:      ctrl_rdata_d = CTRL_DATA_WIDTH'(end_en_q);
      c_addr_start_addr:  ctrl_rdata_d = start_addr_q;
      c_addr_end_addr:    ctrl_rdata_d = end_addr_q;
      c_addr_lower_en:    ctrl_rdata_d = CTRL_DATA_WIDTH'(lower_en_q);
      c_addr_upper_en:    ctrl_rdata_d = CTRL_DATA_WIDTH'(upper_en_q);
      c_addr_lower_bound: ctrl_rdata_d = lower_bound_q;
      c_addr_upper_bound: ctrl_rdata_d = upper_bound_q;
      c_addr_wfi_stopped: ctrl_rdata_d = CTRL_DATA_WIDTH'(wfi_stopped_q);
      c_addr_clk_counter: ctrl_rdata_d = CTRL_DATA_WIDTH'(clk_counter_q);
      c_addr_last_ts:     ctrl_rdata_d = CTRL_DATA_WIDTH'(last_ts_q);
      default: ;
    endcase
  end

  // Next state: WFI outranks the end trigger; a start match never ends the window.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_wait_start: begin
        if (!start_en_q || w_start_hit) state_d = c_st_tracing;
      end
      c_st_tracing: begin
        if (w_is_wfi)       state_d = c_st_halted;
        else if (w_end_hit) state_d = c_st_wait_start;
      end
      c_st_halted: begin
        if (w_halt_release) state_d = c_st_wait_start;
      end
      default: state_d = c_st_wait_start;
    endcase
  end

  always_comb begin
    trace_valid_d = 1'b0;
    case (state_q)
      c_st_wait_start: trace_valid_d = start_en_q && w_start_hit && w_in_range;
      c_st_tracing:    trace_valid_d = instr_valid && w_in_range;
      default:         trace_valid_d = 1'b0;
    endcase
    trace_pc_d    = trace_valid_d ? pc : trace_pc_q;
    trace_instr_d = trace_valid_d ? instr : trace_instr_q;
    tracing_d     = (state_d == c_st_tracing);
    wfi_stopped_d = (state_d == c_st_halted);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= c_st_wait_start;
      start_en_q    <= 1'b0;
      end_en_q      <= 1'b0;
      start_addr_q  <= '0;
      end_addr_q    <= '0;
      lower_en_q    <= 1'b0;
      upper_en_q    <= 1'b0;
      lower_bound_q <= '0;
      upper_bound_q <= '0;
      clk_counter_q <= '0;
      last_ts_q     <= '0;
      ctrl_rdata_q  <= '0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_instr_q <= '0;
      tracing_q     <= 1'b0;
      wfi_stopped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_en_q    <= start_en_d;
      end_en_q      <= end_en_d;
      start_addr_q  <= start_addr_d;
      end_addr_q    <= end_addr_d;
      lower_en_q    <= lower_en_d;
      upper_en_q    <= upper_en_d;
      lower_bound_q <= lower_bound_d;
      upper_bound_q <= upper_bound_d;
      clk_counter_q <= clk_counter_d;
      last_ts_q     <= last_ts_d;
      ctrl_rdata_q  <= ctrl_rdata_d;
      trace_valid_q <= trace_valid_d;
      trace_pc_q    <= trace_pc_d;
      trace_instr_q <= trace_instr_d;
      tracing_q     <= tracing_d;
      wfi_stopped_q <= wfi_stopped_d;
    end
  end

  assign ctrl_rdata  = ctrl_rdata_q;
  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_instr = trace_instr_q;
  assign tracing     = tracing_q;
  assign wfi_stopped = wfi_stopped_q;
  assign clk_counter = clk_counter_q;

endmodule
`default_nettype wire

// File: tb/tb_cms_trace_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cms_trace_controller
// Brief    : Table-driven self-checking bench for cms_trace_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cms_trace_controller;

  localparam logic [31:0] c_nop = 32'h00000013;
  localparam logic [31:0] c_wfi = 32'h10500073;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [63:0] pc = '0;
  logic [31:0] instr = '0;
  logic        ctrl_wen = 1'b0;
  logic [7:0]  ctrl_waddr = '0;
  logic [63:0] ctrl_wdata = '0;
  logic [7:0]  ctrl_raddr = '0;
  logic [63:0] ctrl_rdata;
  logic        trace_valid;
  logic [63:0] trace_pc;
  logic [31:0] trace_instr;
  logic        tracing;
  logic        wfi_stopped;
  logic [63:0] clk_counter;

  int n_cmp = 0;
  int n_err = 0;

  cms_trace_controller #(.XLEN(64), .CTRL_ADDR_WIDTH(8), .CTRL_DATA_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc(pc), .instr(instr),
    .ctrl_wen(ctrl_wen), .ctrl_waddr(ctrl_waddr), .ctrl_wdata(ctrl_wdata),
    .ctrl_raddr(ctrl_raddr), .ctrl_rdata(ctrl_rdata), .trace_valid(trace_valid),
    .trace_pc(trace_pc), .trace_instr(trace_instr), .tracing(tracing),
    .wfi_stopped(wfi_stopped), .clk_counter(clk_counter)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [7:0]  wa;
    logic [63:0] wd;
    logic [7:0]  ra;
    logic        iv;
    logic [63:0] pc;
    logic        etv;
    logic [63:0] epc;
    logic        etr;
    logic        chk_rd;
    logic [63:0] erd;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic cyc(input logic wen, input logic [7:0] wa, input logic [63:0] wd,
                     input logic [7:0] ra, input logic iv, input logic [63:0] p,
                     input logic [31:0] ins);
    @(negedge clk);
    ctrl_wen = wen; ctrl_waddr = wa; ctrl_wdata = wd; ctrl_raddr = ra;
    instr_valid = iv; pc = p; instr = ins;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'd0,  64'h1,    8'd0,  1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b0, 64'h0};
    vecs[1]  = '{1'b1, 8'd1,  64'h1,    8'd0,  1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b0, 64'h0};
    vecs[2]  = '{1'b1, 8'd3,  64'h0FF0, 8'd0,  1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b0, 64'h0};
    vecs[3]  = '{1'b1, 8'd2,  64'h1000, 8'd1,  1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b1, 64'h1};
    vecs[4]  = '{1'b0, 8'd0,  64'h0,    8'd3,  1'b1, 64'h0FF0, 1'b1, 64'h0FF0, 1'b0, 1'b1, 64'h0FF0};
    vecs[5]  = '{1'b0, 8'd0,  64'h0,    8'd0,  1'b1, 64'h0FFC, 1'b0, 64'h0,    1'b0, 1'b1, 64'h1};
    vecs[6]  = '{1'b0, 8'd0,  64'h0,    8'd0,  1'b1, 64'h1000, 1'b1, 64'h1000, 1'b1, 1'b0, 64'h0};
    vecs[7]  = '{1'b0, 8'd0,  64'h0,    8'd0,  1'b1, 64'h1004, 1'b1, 64'h1004, 1'b1, 1'b0, 64'h0};
    vecs[8]  = '{1'b0, 8'd0,  64'h0,    8'd2,  1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b1, 64'h1000};
    vecs[9]  = '{1'b1, 8'd6,  64'h2000, 8'd0,  1'b1, 64'h1FFC, 1'b1, 64'h1FFC, 1'b1, 1'b0, 64'h0};
    vecs[10] = '{1'b1, 8'd7,  64'h2FFF, 8'd6,  1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b1, 64'h2000};
    vecs[11] = '{1'b1, 8'd4,  64'h1,    8'd0,  1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b0, 64'h0};
    vecs[12] = '{1'b1, 8'd5,  64'h1,    8'd0,  1'b1, 64'h1FFC, 1'b0, 64'h0,    1'b1, 1'b0, 64'h0};
    vecs[13] = '{1'b0, 8'd0,  64'h0,    8'd0,  1'b1, 64'h1FFC, 1'b0, 64'h0,    1'b1, 1'b0, 64'h0};
    vecs[14] = '{1'b0, 8'd0,  64'h0,    8'd0,  1'b1, 64'h2000, 1'b1, 64'h2000, 1'b1, 1'b0, 64'h0};
    vecs[15] = '{1'b0, 8'd0,  64'h0,    8'd0,  1'b1, 64'h2FFF, 1'b1, 64'h2FFF, 1'b1, 1'b0, 64'h0};
    vecs[16] = '{1'b0, 8'd0,  64'h0,    8'd0,  1'b1, 64'h3000, 1'b0, 64'h0,    1'b1, 1'b0, 64'h0};
    vecs[17] = '{1'b0, 8'd0,  64'h0,    8'd0,  1'b1, 64'h2800, 1'b1, 64'h2800, 1'b1, 1'b0, 64'h0};
    vecs[18] = '{1'b0, 8'd0,  64'h0,    8'd5,  1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b1, 64'h1};
    vecs[19] = '{1'b1, 8'd11, 64'hFFFF, 8'd7,  1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b1, 64'h2FFF};
    vecs[20] = '{1'b0, 8'd0,  64'h0,    8'd11, 1'b0, 64'h0,    1'b0, 64'h0,    1'b1, 1'b1, 64'h0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_trace_valid", {63'd0, trace_valid}, 64'd0);
    chk("reset_tracing", {63'd0, tracing}, 64'd0);
    chk("reset_wfi_stopped", {63'd0, wfi_stopped}, 64'd0);
    chk("reset_clk_counter", clk_counter, 64'd0);
    chk("reset_rdata", ctrl_rdata, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Start trigger and range filter vectors
    for (int i = 0; i < 21; i++) begin
      cyc(vecs[i].wen, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].iv, vecs[i].pc, c_nop);
      chk($sformatf("vec%0d_trace_valid", i), {63'd0, trace_valid}, {63'd0, vecs[i].etv});
      chk($sformatf("vec%0d_tracing", i), {63'd0, tracing}, {63'd0, vecs[i].etr});
      chk($sformatf("vec%0d_wfi_stopped", i), {63'd0, wfi_stopped}, 64'd0);
      if (vecs[i].etv) begin
        chk($sformatf("vec%0d_trace_pc", i), trace_pc, vecs[i].epc);
        chk($sformatf("vec%0d_trace_instr", i), {32'd0, trace_instr}, {32'd0, c_nop});
      end
      if (vecs[i].chk_rd)
        chk($sformatf("vec%0d_rdata", i), ctrl_rdata, vecs[i].erd);
    end

    // Counter load, wrap, and last-write timestamp
    cyc(1'b1, 8'd9, 64'hFFFF_FFFF_FFFF_FFFE, 8'd0, 1'b0, 64'h0, c_nop);
    chk("cnt_load", clk_counter, 64'hFFFF_FFFF_FFFF_FFFE);
    cyc(1'b0, 8'd0, 64'h0, 8'd0, 1'b0, 64'h0, c_nop);
    chk("cnt_max", clk_counter, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(1'b0, 8'd0, 64'h0, 8'd9, 1'b0, 64'h0, c_nop);
    chk("cnt_wrap", clk_counter, 64'h0);
    chk("cnt_read_max", ctrl_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc(1'b0, 8'd0, 64'h0, 8'd9, 1'b0, 64'h0, c_nop);
    chk("cnt_read_zero", ctrl_rdata, 64'h0);
    cyc(1'b1, 8'd3, 64'h2100, 8'd0, 1'b0, 64'h0, c_nop);
    cyc(1'b0, 8'd0, 64'h0, 8'd10, 1'b0, 64'h0, c_nop);
    chk("last_write_ts", ctrl_rdata, 64'h1);

`ifdef CMS_WFI_HALT_EN
    cyc(1'b0, 8'd0, 64'h0, 8'd0, 1'b1, 64'h2200, c_wfi);
    chk("wfi_trace_valid", {63'd0, trace_valid}, 64'd1);
    chk("wfi_trace_instr", {32'd0, trace_instr}, {32'd0, c_wfi});
    chk("wfi_stopped_set", {63'd0, wfi_stopped}, 64'd1);
    chk("wfi_tracing_drop", {63'd0, tracing}, 64'd0);
    cyc(1'b0, 8'd0, 64'h0, 8'd8, 1'b1, 64'h2204, c_nop);
    chk("halted_no_trace", {63'd0, trace_valid}, 64'd0);
    chk("halted_read8", ctrl_rdata, 64'd1);
    cyc(1'b1, 8'd8, 64'h5, 8'd0, 1'b0, 64'h0, c_nop);
    chk("halted_nonzero_ignored", {63'd0, wfi_stopped}, 64'd1);
    cyc(1'b1, 8'd0, 64'h0, 8'd0, 1'b0, 64'h0, c_nop);
    cyc(1'b1, 8'd8, 64'h0, 8'd0, 1'b0, 64'h0, c_nop);
    chk("release_wfi_stopped", {63'd0, wfi_stopped}, 64'd0);
    chk("release_wait_start", {63'd0, tracing}, 64'd0);
    cyc(1'b0, 8'd0, 64'h0, 8'd0, 1'b0, 64'h0, c_nop);
    chk("resume_tracing", {63'd0, tracing}, 64'd1);
    cyc(1'b0, 8'd0, 64'h0, 8'd0, 1'b1, 64'h2100, c_wfi);
    chk("collide_trace_valid", {63'd0, trace_valid}, 64'd1);
    chk("collide_trace_pc", trace_pc, 64'h2100);
    chk("collide_halt_wins", {63'd0, wfi_stopped}, 64'd1);
    cyc(1'b1, 8'd8, 64'h0, 8'd0, 1'b0, 64'h0, c_nop);
    cyc(1'b0, 8'd0, 64'h0, 8'd0, 1'b0, 64'h0, c_nop);
    chk("resume2_tracing", {63'd0, tracing}, 64'd1);
`else
    cyc(1'b0, 8'd0, 64'h0, 8'd0, 1'b1, 64'h2200, c_wfi);
    chk("wfi_plain_trace_valid", {63'd0, trace_valid}, 64'd1);
    chk("wfi_plain_trace_instr", {32'd0, trace_instr}, {32'd0, c_wfi});
    chk("wfi_plain_no_halt", {63'd0, wfi_stopped}, 64'd0);
    chk("wfi_plain_tracing", {63'd0, tracing}, 64'd1);
    cyc(1'b0, 8'd0, 64'h0, 8'd8, 1'b1, 64'h2204, c_nop);
    chk("wfi_plain_next_traced", {63'd0, trace_valid}, 64'd1);
    chk("wfi_plain_read8", ctrl_rdata, 64'd0);
    cyc(1'b1, 8'd8, 64'h0, 8'd8, 1'b0, 64'h0, c_nop);
    chk("wfi_plain_write8_tracing", {63'd0, tracing}, 64'd1);
    chk("wfi_plain_read8_again", ctrl_rdata, 64'd0);
`endif

    // Reset while a trace pulse is on the outputs
    cyc(1'b0, 8'd0, 64'h0, 8'd2, 1'b1, 64'h2300, c_nop);
    chk("pre_reset_trace_valid", {63'd0, trace_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_trace_valid", {63'd0, trace_valid}, 64'd0);
    chk("midreset_tracing", {63'd0, tracing}, 64'd0);
    chk("midreset_wfi_stopped", {63'd0, wfi_stopped}, 64'd0);
    chk("midreset_clk_counter", clk_counter, 64'd0);
    chk("midreset_rdata", ctrl_rdata, 64'd0);
    chk("midreset_trace_pc", trace_pc, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a <= 10; a++) begin
      if (a != 9) begin
        cyc(1'b0, 8'd0, 64'h0, 8'(a), 1'b0, 64'h0, c_nop);
        chk($sformatf("post_reset_reg%0d", a), ctrl_rdata, 64'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
